// File: rtl/keypad_scan_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner: FSM states, matrix
// dimensions and the row/col-to-code mapping.
package keypad_scan_pkg;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;
    localparam int KEY_W    = 4;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_DB,
        HELD,
        RELEASE_DB
    } kp_state_t;

    // code = row*4 + col
    function automatic logic [KEY_W-1:0] key_code_of(input logic [1:0] row, input logic [1:0] col);
        return {row, col};
    endfunction

endpackage

// File: rtl/keypad_fifo.sv
// Depth-4 synchronous key-code FIFO; only instantiated when KEYPAD_FIFO_EN is defined.
module keypad_fifo
    import keypad_scan_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [KEY_W-1:0] din,
    input  logic             pop,
    output logic [KEY_W-1:0] dout,
    output logic             full,
    output logic             empty
);

    logic [3:0][KEY_W-1:0] mem;
    logic [1:0]            wr_ptr, rd_ptr;
    logic [2:0]            cnt;
    logic                  do_pop, do_push;

    assign full    = (cnt == 3'd4);
    assign empty   = (cnt == 3'd0);
    assign dout    = mem[rd_ptr];
    assign do_pop  = pop && !empty;
    // a pop in the same cycle frees the slot, so push-while-full is allowed then
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (!rst) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 2'd1;
            end
            if (do_pop)
                rd_ptr <= rd_ptr + 2'd1;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 3'd1;
                2'b01:   cnt <= cnt - 3'd1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner with debounce and valid/ready key output.
// Define KEYPAD_FIFO_EN for a 4-entry output FIFO instead of a single register.
module keypad_scan
    import keypad_scan_pkg::*;
#(
    parameter int SCAN_DIV       = 25000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [NUM_ROWS-1:0] row_in,
    output logic [NUM_COLS-1:0] col_out,
    output logic [KEY_W-1:0]    key_code,
    output logic                key_valid,
    input  logic                key_ready,
    output logic                key_held,
    output logic                overflow
);

    localparam int               DIV_W    = $clog2(SCAN_DIV + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [3:0]       DB_TGT   = 4'(DEBOUNCE_SCANS);

    logic [NUM_ROWS-1:0] row_s1, row_s2;
    logic [DIV_W-1:0]    div_cnt;
    logic [1:0]          col_idx, col_idx_nx;
    logic                sample, scan_end;

    always_ff @(posedge clk) begin
        if (!rst) begin
            row_s1 <= '1;
            row_s2 <= '1;
        end else begin
            row_s1 <= row_in;
            row_s2 <= row_s1;
        end
    end

    assign sample     = en && (div_cnt == DIV_LAST);
    assign scan_end   = sample && (col_idx == 2'(NUM_COLS - 1));
    assign col_idx_nx = (div_cnt == DIV_LAST) ? col_idx + 2'd1 : col_idx;

    always_ff @(posedge clk) begin
        if (!rst || !en) begin
            div_cnt <= '0;
            col_idx <= '0;
            col_out <= '1;
        end else begin
            div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_W'(1);
            col_idx <= col_idx_nx;
            col_out <= ~(4'b0001 << col_idx_nx);
        end
    end

    // Per-scan accumulation: key count saturates at 2 (multi), code kept from the first hit
    logic [1:0]       hit_n, acc_n, tot_n;
    logic [1:0]       hit_row;
    logic [2:0]       sum_n;
    logic [KEY_W-1:0] acc_code, scan_code;

    always_comb begin
        hit_n   = '0;
        hit_row = '0;
        for (int r = NUM_ROWS - 1; r >= 0; r--) begin
            if (!row_s2[r]) begin
                hit_row = 2'(r);
                if (hit_n != 2'd2)
                    hit_n = hit_n + 2'd1;
            end
        end
        sum_n     = {1'b0, acc_n} + {1'b0, hit_n};
        tot_n     = (sum_n >= 3'd2) ? 2'd2 : sum_n[1:0];
        scan_code = (acc_n == 2'd0) ? key_code_of(hit_row, col_idx) : acc_code;
    end

    always_ff @(posedge clk) begin
        if (!rst || !en) begin
            acc_n    <= '0;
            acc_code <= '0;
        end else if (sample) begin
            acc_n    <= (col_idx == 2'(NUM_COLS - 1)) ? 2'd0 : tot_n;
            acc_code <= scan_code;
        end
    end

    kp_state_t        state, state_nx;
    logic [3:0]       db_cnt, db_nx;
    logic [KEY_W-1:0] cand, cand_nx;
    logic             emit, res_none, res_single;

    assign res_none   = (tot_n == 2'd0);
    assign res_single = (tot_n == 2'd1);

    always_ff @(posedge clk) begin
        if (!rst || !en) begin
            state  <= IDLE;
            db_cnt <= '0;
            cand   <= '0;
        end else begin
            state  <= state_nx;
            db_cnt <= db_nx;
            cand   <= cand_nx;
        end
    end

    always_comb begin
        state_nx = state;
        db_nx    = db_cnt;
        cand_nx  = cand;
        emit     = 1'b0;
        if (scan_end) begin
            case (state)
                IDLE: if (res_single) begin
                    cand_nx = scan_code;
                    db_nx   = 4'd1;
                    if (DEBOUNCE_SCANS == 1) begin
                        state_nx = HELD;
                        emit     = 1'b1;
                    end else
                        state_nx = PRESS_DB;
                end
                PRESS_DB: if (res_single && scan_code == cand) begin
                    db_nx = db_cnt + 4'd1;
                    if (db_cnt + 4'd1 == DB_TGT) begin
                        state_nx = HELD;
                        emit     = 1'b1;
                    end
                end else begin
                    state_nx = IDLE;
                    db_nx    = '0;
                end
                HELD: if (res_none) begin
                    db_nx    = 4'd1;
                    state_nx = (DEBOUNCE_SCANS == 1) ? IDLE : RELEASE_DB;
                end
                RELEASE_DB: if (res_none) begin
                    db_nx = db_cnt + 4'd1;
                    if (db_cnt + 4'd1 == DB_TGT)
                        state_nx = IDLE;
                end else
                    state_nx = HELD;
                default: state_nx = IDLE;
            endcase
        end
    end

    // The key stays "held" until its release has been debounced
    assign key_held = (state == HELD) || (state == RELEASE_DB);

`ifdef KEYPAD_FIFO_EN
    logic fifo_full, fifo_empty, fifo_pop;

    assign fifo_pop  = !fifo_empty && key_ready;
    assign key_valid = !fifo_empty;

    keypad_fifo u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (emit),
        .din   (scan_code),
        .pop   (fifo_pop),
        .dout  (key_code),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (!rst)
            overflow <= 1'b0;
        else if (emit && fifo_full && !fifo_pop)
            overflow <= 1'b1;
    end
`else
    always_ff @(posedge clk) begin
        if (!rst) begin
            key_code  <= '0;
            key_valid <= 1'b0;
            overflow  <= 1'b0;
        end else if (emit) begin
            if (key_valid && !key_ready)
                overflow <= 1'b1;
            else begin
                key_code  <= scan_code;
                key_valid <= 1'b1;
            end
        end else if (key_valid && key_ready)
            key_valid <= 1'b0;
    end
`endif

endmodule

// File: doc/keypad_scan.md
# keypad_scan

Matrix-keypad scanner for the 4x4 hex keypad on the board: the input-side counterpart of the multiplexed 7-segment driver. It walks an active-low column strobe across the keypad at the same scan-rate style as the display, synchronises and debounces the row returns, and emits one 4-bit key code per debounced press on a valid/ready interface. Its codes feed the project's control logic, whose digits end up on the segment display.

## Interface
- SCAN_DIV, 25000: clk cycles per column period.
- DEBOUNCE_SCANS, 4: consecutive identical full scans required to accept a press or a release; legal range 1..15.
- clk  in  1  system clock.
- rst  in  1  synchronous, active-low reset (one clock; reset is synchronous and active-low).
- en  in  1  scan enable.
- row_in  in  4  keypad rows, active-low, pulled up externally, asynchronous.
- col_out  out  4  column strobe, active-low one-hot; 4'b1111 means no column driven.
- key_code  out  4  code of the accepted key = row*4 + col.
- key_valid  out  1  key_code holds an undelivered event.
- key_ready  in  1  consumer accepts key_code.
- key_held  out  1  a debounced key is currently held.
- overflow  out  1  sticky flag: an event was dropped; cleared only by rst.

## Operation
- row_in passes through a 2-flop synchroniser before any use.
- Column counter col_idx 0..3, with div_cnt counting 0..SCAN_DIV-1. On div_cnt wrap, col_idx advances (3 wraps to 0) and col_out = ~(1<<col_idx).
- Rows are sampled on the last cycle of each column period (div_cnt == SCAN_DIV-1). Low rows in the sample mark keys (row, col_idx).
- A full scan ends on the sample taken at col_idx == 3. Scan result:
  - none: 0 keys pressed.
  - single code: exactly 1 key pressed.
  - multi: 2 or more keys pressed. Multi is treated as invalid and never emitted.
- FSM states IDLE, PRESS_DB, HELD, RELEASE_DB. A 4-bit db_cnt counts scans. All transitions occur at scan end.
  - IDLE: a single code latches cand, sets db_cnt = 1 and goes to PRESS_DB. If DEBOUNCE_SCANS == 1, it goes directly to HELD and emits.
  - PRESS_DB: the same code increments db_cnt. When db_cnt reaches DEBOUNCE_SCANS, the FSM emits cand and goes to HELD. Any other result (none, multi or a different code) returns to IDLE.
  - HELD: key_held = 1. A none result goes to RELEASE_DB with db_cnt = 1. Any other result stays in HELD, so a held key never repeats.
  - RELEASE_DB: none increments db_cnt; at DEBOUNCE_SCANS the FSM goes to IDLE. Any non-none result returns to HELD.
- Emit writes cand into the output stage.
  - Default build: a single holding register. If key_valid is already 1 and no transfer occurs in the same cycle, the event is dropped and overflow is set.
  - Emit and transfer in the same cycle: the register is reloaded and key_valid stays 1.
- A transfer is a cycle with key_valid && key_ready. key_code must not change while key_valid && !key_ready.
- en low:
  - col_out goes to 4'b1111 the next cycle.
  - div_cnt, col_idx and db_cnt are cleared; the FSM goes to IDLE and key_held goes to 0.
  - The output stage keeps its contents and the handshake stays live.
- en rising: scanning restarts at col_idx 0 with div_cnt 0.

## Timing
- Reset values: col_out 4'b1111, key_code 0, key_valid 0, key_held 0, overflow 0, FSM in IDLE, all counters 0.
- First cycle after reset with en high loads col_out = 4'b1110.
- A row change reaches the sample point after 2 cycles of synchroniser delay. Rows must be stable 2 cycles before the column period ends.
- Press latency: key_valid rises 1 cycle after the scan-end sample that completes debounce. key_held rises on the same cycle.
- Minimum press-to-valid time: (DEBOUNCE_SCANS-1)*4*SCAN_DIV cycles plus the time to reach the first scan end, plus 1.
- key_valid falls the cycle after a transfer unless a new emit occurs in that cycle.
- Reset mid-operation discards all state. A key still held after reset is re-detected and emitted again after a full debounce.

## Configuration
- KEYPAD_FIFO_EN defined: the output stage is a 4-entry FIFO.
  - key_valid means the FIFO is not empty; key_code is the head entry.
  - Emit while full with no same-cycle pop drops the event and sets overflow.
  - Emit into an empty FIFO produces key_valid the next cycle.
  - Simultaneous push and pop while full is accepted.
- KEYPAD_FIFO_EN undefined: single holding register as described in Operation.

## Structure
- Shared package holds the FSM state enum and localparams NUM_ROWS = 4, NUM_COLS = 4 and KEY_W = 4.
- Shared package also holds the row/col-to-code function, used by the bench scoreboard as well.
- One sub-module, keypad_fifo, used only under KEYPAD_FIFO_EN. It is a depth-4, width-4 synchronous FIFO with full/empty flags and the same clk/rst.

## Test plan
Test plan parameters: SCAN_DIV = 4, DEBOUNCE_SCANS = 2, key_ready = 1 unless stated. The bench models the key matrix by driving row_in from col_out.

- Hold key row 1, col 2 for 5 scans, then release → exactly one event with key_code = 0x6. key_held = 1 until 2 none-scans after release.
- Key row 0, col 0 pressed for only 1 scan, repeated 3 times with release scans between → no key_valid, state never reaches HELD.
- Keys (2,1) and (3,3) held together for 4 scans → no event, key_held stays 0.
- key_ready = 0; press and release 0x3, then 0xA:
  - Default build: only 0x3 is delivered once ready rises, and overflow = 1.
  - KEYPAD_FIFO_EN build: 0x3 then 0xA are delivered in order, and overflow = 0.
- en dropped in PRESS_DB → col_out = 4'b1111 the next cycle, no event. With the key still held after en returns, 0xF emits after a full debounce.
- rst asserted for 1 cycle while in HELD with key_valid = 1 → all outputs at reset values the next cycle. With the key still held, it re-emits after debounce.
